// File: rtl/oled_spi_rx_if.sv
// Serial command port of the OLED panel plus the decoded panel state seen by the receiver.
// master = serial driver / observer side, slave = oled_spi_rx.
interface oled_spi_rx_if;
    logic       cs;
    logic       sclk;
    logic       sdin;
    logic       dc;
    logic       res;
    logic       vddc;
    logic       vbatc;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_is_cmd;
    logic       display_on;
    logic       charge_pump_on;
    logic [7:0] precharge;
    logic       seg_remap;
    logic       com_scan_rev;
    logic [7:0] com_pins;
    logic       cmd_error;
    logic       seq_error;

    modport master (
        output cs, sclk, sdin, dc, res, vddc, vbatc,
        input  byte_valid, byte_data, byte_is_cmd, display_on, charge_pump_on,
               precharge, seg_remap, com_scan_rev, com_pins, cmd_error, seq_error
    );

    modport slave (
        input  cs, sclk, sdin, dc, res, vddc, vbatc,
        output byte_valid, byte_data, byte_is_cmd, display_on, charge_pump_on,
               precharge, seg_remap, com_scan_rev, com_pins, cmd_error, seq_error
    );
endinterface

// File: rtl/oled_spi_rx.sv
// Receives the OLED serial command port, deserialises MSB-first bytes and decodes the SSD1306 power-up subset.
// Latency: byte_valid/decoded state update 1 cycle after the 8th synchronised sclk rise (pin-to-output ~4 cycles).
// No backpressure: the port is receive-only. OLED_SPI_RX_SEQCHK_EN adds the sticky power-sequence checker.
module oled_spi_rx (
    input  logic          clock,
    input  logic          reset,
    oled_spi_rx_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, ARG = 1'b1} state_t;

    localparam logic [7:0] OP_DISP_OFF = 8'hAE;
    localparam logic [7:0] OP_DISP_ON  = 8'hAF;
    localparam logic [7:0] OP_SEG_0    = 8'hA0;
    localparam logic [7:0] OP_SEG_1    = 8'hA1;
    localparam logic [7:0] OP_COM_0    = 8'hC0;
    localparam logic [7:0] OP_COM_1    = 8'hC8;
    localparam logic [7:0] OP_CPUMP    = 8'h8D;
    localparam logic [7:0] OP_PRECHG   = 8'hD9;
    localparam logic [7:0] OP_COMPINS  = 8'hDA;

    localparam logic [7:0] PRECHG_RST  = 8'h22;
    localparam logic [7:0] COMPINS_RST = 8'h12;

    // Synchroniser bit order {cs, sclk, sdin, dc, res, vddc, vbatc}; active-low pins idle high.
    localparam logic [6:0] SYNC_RST = 7'b100_0111;

    logic [6:0] sync1_q, sync1_d;
    logic [6:0] sync2_q, sync2_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;

    logic       cs_s, sclk_s, sdin_s, dc_s, res_s, vddc_s, vbatc_s;
    logic       sclk_rise;
    logic       bit_accept;
    logic       byte_done;
    logic [7:0] byte_word;

    state_t     state_q;
    logic [7:0] opcode_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_is_cmd_q;
    logic       display_on_q;
    logic       charge_pump_on_q;
    logic [7:0] precharge_q;
    logic       seg_remap_q;
    logic       com_scan_rev_q;
    logic [7:0] com_pins_q;
    logic       cmd_error_q;
    logic       seq_error_q;

    assign {cs_s, sclk_s, sdin_s, dc_s, res_s, vddc_s, vbatc_s} = sync2_q;

    // Deserialiser and synchronisers
    always_comb begin
        sync1_d     = {bus.cs, bus.sclk, bus.sdin, bus.dc, bus.res, bus.vddc, bus.vbatc};
        sync2_d     = sync1_q;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;

        sclk_rise  = sclk_s & ~sclk_prev_q;
        // A rise coincident with cs going high still counts; the abort takes effect next cycle.
        bit_accept = sclk_rise & (~cs_s | ~cs_prev_q);
        byte_word  = {shift_q, sdin_s};
        byte_done  = bit_accept & (cnt_q == 3'd7) & res_s;

        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (!res_s) begin
            cnt_d   = 3'd0;
            shift_d = 7'd0;
        end else if (bit_accept) begin
            cnt_d   = cnt_q + 3'd1;
            shift_d = byte_word[6:0];
        end else if (cs_s) begin
            cnt_d   = 3'd0;
            shift_d = 7'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= SYNC_RST;
            sync2_q     <= SYNC_RST;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            cnt_q       <= 3'd0;
            shift_q     <= 7'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
        end
    end

    // Command decoder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            opcode_q         <= 8'h00;
            byte_valid_q     <= 1'b0;
            byte_data_q      <= 8'h00;
            byte_is_cmd_q    <= 1'b0;
            display_on_q     <= 1'b0;
            charge_pump_on_q <= 1'b0;
            precharge_q      <= PRECHG_RST;
            seg_remap_q      <= 1'b0;
            com_scan_rev_q   <= 1'b0;
            com_pins_q       <= COMPINS_RST;
            cmd_error_q      <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            if (!res_s) begin
                state_q          <= IDLE;
                opcode_q         <= 8'h00;
                byte_data_q      <= 8'h00;
                byte_is_cmd_q    <= 1'b0;
                display_on_q     <= 1'b0;
                charge_pump_on_q <= 1'b0;
                precharge_q      <= PRECHG_RST;
                seg_remap_q      <= 1'b0;
                com_scan_rev_q   <= 1'b0;
                com_pins_q       <= COMPINS_RST;
            end else if (byte_done) begin
                byte_valid_q  <= 1'b1;
                byte_data_q   <= byte_word;
                byte_is_cmd_q <= ~dc_s;
                if (state_q == ARG) begin
                    state_q  <= IDLE;
                    opcode_q <= 8'h00;
                    if (dc_s) begin
                        cmd_error_q <= 1'b1;
                    end else begin
                        case (opcode_q)
                            OP_CPUMP:   charge_pump_on_q <= byte_word[2];
                            OP_PRECHG:  precharge_q      <= byte_word;
                            OP_COMPINS: com_pins_q       <= byte_word;
                            default:    cmd_error_q      <= 1'b1;
                        endcase
                    end
                end else if (!dc_s) begin
                    case (byte_word)
                        OP_DISP_OFF: display_on_q   <= 1'b0;
                        OP_DISP_ON:  display_on_q   <= 1'b1;
                        OP_SEG_0:    seg_remap_q    <= 1'b0;
                        OP_SEG_1:    seg_remap_q    <= 1'b1;
                        OP_COM_0:    com_scan_rev_q <= 1'b0;
                        OP_COM_1:    com_scan_rev_q <= 1'b1;
                        OP_CPUMP, OP_PRECHG, OP_COMPINS: begin
                            opcode_q <= byte_word;
                            state_q  <= ARG;
                        end
                        default:     cmd_error_q    <= 1'b1;
                    endcase
                end
            end
        end
    end

`ifdef OLED_SPI_RX_SEQCHK_EN
    logic vddc_prev_q, vddc_prev_d;
    logic seq_error_d;
    logic af_rx;

    always_comb begin
        vddc_prev_d = vddc_s;
        af_rx       = byte_done & (state_q == IDLE) & ~dc_s & (byte_word == OP_DISP_ON);
        seq_error_d = seq_error_q
                    | (~vbatc_s & vddc_s)
                    | (af_rx & (vbatc_s | ~charge_pump_on_q))
                    | (~vddc_prev_q & vddc_s & ~vbatc_s);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vddc_prev_q <= 1'b1;
            seq_error_q <= 1'b0;
        end else begin
            vddc_prev_q <= vddc_prev_d;
            seq_error_q <= seq_error_d;
        end
    end
`else
    logic unused_supply;
    assign unused_supply = vddc_s ^ vbatc_s;
    assign seq_error_q   = 1'b0;
`endif

    assign bus.byte_valid     = byte_valid_q;
    assign bus.byte_data      = byte_data_q;
    assign bus.byte_is_cmd    = byte_is_cmd_q;
    assign bus.display_on     = display_on_q;
    assign bus.charge_pump_on = charge_pump_on_q;
    assign bus.precharge      = precharge_q;
    assign bus.seg_remap      = seg_remap_q;
    assign bus.com_scan_rev   = com_scan_rev_q;
    assign bus.com_pins       = com_pins_q;
    assign bus.cmd_error      = cmd_error_q;
    assign bus.seq_error      = seq_error_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: power-up table, hand-written corner sequences, then random bytes against a panel-state model.
module tb_oled_spi_rx;

`ifdef OLED_SPI_RX_SEQCHK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    oled_spi_rx_if bus();
    oled_spi_rx dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int bv_cnt   = 0;
    int ce_cnt   = 0;

    // Reference panel state
    bit       m_disp, m_cp, m_seg, m_com, m_is_cmd, m_seq;
    bit [7:0] m_pre, m_pins, m_last, m_pend;
    int       m_bytes, m_errs;

    typedef struct {
        bit [7:0] b;
        bit       is_data;
        bit       disp;
        bit       cp;
        bit [7:0] pre;
        bit       seg;
        bit       com;
        bit [7:0] pins;
    } vec_t;
    vec_t tbl[10];

    always @(negedge clock) begin
        if (bus.byte_valid === 1'b1) bv_cnt++;
        if (bus.cmd_error === 1'b1)  ce_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic m_panel_reset();
        m_disp = 0; m_cp = 0; m_seg = 0; m_com = 0;
        m_pre = 8'h22; m_pins = 8'h12; m_pend = 8'h00;
        m_last = 8'h00; m_is_cmd = 0;
    endtask

    task automatic m_byte(input bit [7:0] b, input bit is_data);
        m_bytes++;
        m_last   = b;
        m_is_cmd = !is_data;
        if (m_pend != 8'h00) begin
            if (is_data) m_errs++;
            else if (m_pend == 8'h8D) m_cp = b[2];
            else if (m_pend == 8'hD9) m_pre = b;
            else m_pins = b;
            m_pend = 8'h00;
        end else if (!is_data) begin
            case (b)
                8'hAE: m_disp = 0;
                8'hAF: begin
                    if (SEQ && (bus.vbatc || !m_cp)) m_seq = 1;
                    m_disp = 1;
                end
                8'hA0: m_seg = 0;
                8'hA1: m_seg = 1;
                8'hC0: m_com = 0;
                8'hC8: m_com = 1;
                8'h8D, 8'hD9, 8'hDA: m_pend = b;
                default: m_errs++;
            endcase
        end
    endtask

    task automatic send_bits(input bit [7:0] b, input bit d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clock);
            bus.sdin = b[i];
            bus.dc   = d;
            repeat (3) @(negedge clock);
            bus.sclk = 1'b1;
            repeat (3) @(negedge clock);
            bus.sclk = 1'b0;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic send_byte(input bit [7:0] b, input bit is_data);
        send_bits(b, is_data, 8);
        m_byte(b, is_data);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".display_on"},     bus.display_on,     m_disp);
        chk({tag, ".charge_pump_on"}, bus.charge_pump_on, m_cp);
        chk({tag, ".precharge"},      bus.precharge,      m_pre);
        chk({tag, ".seg_remap"},      bus.seg_remap,      m_seg);
        chk({tag, ".com_scan_rev"},   bus.com_scan_rev,   m_com);
        chk({tag, ".com_pins"},       bus.com_pins,       m_pins);
        chk({tag, ".byte_data"},      bus.byte_data,      m_last);
        chk({tag, ".byte_is_cmd"},    bus.byte_is_cmd,    m_is_cmd);
        chk({tag, ".byte_count"},     bv_cnt,             m_bytes);
        chk({tag, ".cmd_err_count"},  ce_cnt,             m_errs);
        chk({tag, ".seq_error"},      bus.seq_error,      m_seq);
    endtask

    task automatic pulse_res();
        @(negedge clock); bus.res = 1'b0;
        repeat (5) @(negedge clock); bus.res = 1'b1;
        repeat (4) @(negedge clock);
        m_panel_reset();
    endtask

    initial begin
        bit [7:0] pool[10];
        bit [7:0] b;
        bit       d;
        int       bv_before;

        pool = '{8'hAE, 8'hAF, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'h8D, 8'hD9, 8'hDA, 8'h3C};
        tbl[0] = '{8'hAE, 0, 0, 0, 8'h22, 0, 0, 8'h12};
        tbl[1] = '{8'h8D, 0, 0, 0, 8'h22, 0, 0, 8'h12};
        tbl[2] = '{8'h14, 0, 0, 1, 8'h22, 0, 0, 8'h12};
        tbl[3] = '{8'hD9, 0, 0, 1, 8'h22, 0, 0, 8'h12};
        tbl[4] = '{8'hF1, 0, 0, 1, 8'hF1, 0, 0, 8'h12};
        tbl[5] = '{8'hA1, 0, 0, 1, 8'hF1, 1, 0, 8'h12};
        tbl[6] = '{8'hC8, 0, 0, 1, 8'hF1, 1, 1, 8'h12};
        tbl[7] = '{8'hDA, 0, 0, 1, 8'hF1, 1, 1, 8'h12};
        tbl[8] = '{8'h20, 0, 0, 1, 8'hF1, 1, 1, 8'h20};
        tbl[9] = '{8'hAF, 0, 1, 1, 8'hF1, 1, 1, 8'h20};

        bus.cs = 1; bus.sclk = 0; bus.sdin = 0; bus.dc = 0;
        bus.res = 0; bus.vddc = 1; bus.vbatc = 1;
        m_panel_reset(); m_seq = 0; m_bytes = 0; m_errs = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_model("reset");
        chk("reset.byte_valid", bus.byte_valid, 1'b0);
        chk("reset.cmd_error",  bus.cmd_error,  1'b0);

        // Power-up: release panel reset, logic supply, then panel supply.
        bus.res = 1; repeat (4) @(negedge clock);
        bus.vddc = 0; repeat (4) @(negedge clock);
        bus.vbatc = 0; bus.cs = 0; repeat (4) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i].b, tbl[i].is_data);
            chk($sformatf("pwr%0d.byte_data", i),  bus.byte_data,      tbl[i].b);
            chk($sformatf("pwr%0d.display", i),    bus.display_on,     tbl[i].disp);
            chk($sformatf("pwr%0d.cpump", i),      bus.charge_pump_on, tbl[i].cp);
            chk($sformatf("pwr%0d.precharge", i),  bus.precharge,      tbl[i].pre);
            chk($sformatf("pwr%0d.seg", i),        bus.seg_remap,      tbl[i].seg);
            chk($sformatf("pwr%0d.com", i),        bus.com_scan_rev,   tbl[i].com);
            chk($sformatf("pwr%0d.pins", i),       bus.com_pins,       tbl[i].pins);
        end
        chk("pwr.byte_pulses", bv_cnt, 10);
        chk("pwr.seq_error", bus.seq_error, 1'b0);
        chk_model("pwr");

        // Partial byte aborted by cs, then AF must be decoded as an opcode.
        send_byte(8'hAE, 0);
        bv_before = bv_cnt;
        send_bits(8'h8D, 0, 5);
        bus.cs = 1; repeat (6) @(negedge clock);
        bus.cs = 0; repeat (4) @(negedge clock);
        chk("abort.no_pulse", bv_cnt, bv_before);
        send_byte(8'hAF, 0);
        chk("abort.one_pulse", bv_cnt, bv_before + 1);
        chk("abort.display_on", bus.display_on, 1'b1);
        chk_model("abort");

        // Panel reset restores decoded defaults but keeps seq_error.
        pulse_res();
        chk_model("res");
        chk("res.precharge", bus.precharge, 8'h22);
        chk("res.com_pins",  bus.com_pins,  8'h12);

        // Command awaiting an argument aborted by a data byte.
        bv_before = ce_cnt;
        send_byte(8'h8D, 0);
        send_byte(8'h55, 1);
        chk("argabort.cmd_error", ce_cnt, bv_before + 1);
        chk("argabort.cpump", bus.charge_pump_on, 1'b0);
        chk("argabort.byte_data", bus.byte_data, 8'h55);
        chk("argabort.is_cmd", bus.byte_is_cmd, 1'b0);

        // Unknown opcode.
        send_byte(8'hA1, 0);
        bv_before = ce_cnt;
        send_byte(8'h3C, 0);
        chk("unknown.cmd_error", ce_cnt, bv_before + 1);
        chk_model("unknown");

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            d = ($urandom_range(0, 4) == 0);
            send_byte(b, d);
            chk_model($sformatf("rnd%0d", i));
            if (i == 20) begin
                pulse_res();
                chk_model("rnd.res");
            end
        end

        // Full reset, then AF with the panel supply off.
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        m_panel_reset(); m_seq = 0;
        repeat (4) @(negedge clock);
        chk("reset2.seq_error", bus.seq_error, 1'b0);
        chk("reset2.precharge", bus.precharge, 8'h22);
        bus.vbatc = 1; repeat (4) @(negedge clock);
        send_byte(8'h8D, 0);
        send_byte(8'h14, 0);
        send_byte(8'hAF, 0);
        chk("seq.set", bus.seq_error, SEQ);
        send_byte(8'hAE, 0);
        pulse_res();
        chk("seq.sticky", bus.seq_error, SEQ);
        chk_model("seq");
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("seq.cleared", bus.seq_error, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
